// File: rtl/genevr_reg_pkg.sv
// Shared definitions for the genevr register-bus master: AXI response codes,
// the timeout read-data pattern and the bridge FSM state encoding.
package genevr_reg_pkg;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] DEAD_DATA   = 32'hdead_beef;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUS_WAIT = 2'd1,
    ST_WR_RESP  = 2'd2,
    ST_RD_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/genevr_reg_master.sv
// AXI4-Lite slave to genevr req/ack register-bus bridge. Each single AXI read
// or write becomes exactly one register-bus transaction; partial-strobe writes
// are rejected with SLVERR without touching the bus.
// Optional macro GENEVR_REG_TIMEOUT_EN: abort a bus cycle after TIMEOUT_CYCLES
// without ack (reads return DEAD_DATA, both directions respond SLVERR).
module genevr_reg_master
  import genevr_reg_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 26,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready,
  output logic                        reg_req_out,
  output logic                        reg_rd_wr_L_out,
  output logic [AXI_ADDR_WIDTH-1:0]   reg_addr_out,
  output logic [AXI_DATA_WIDTH-1:0]   reg_wr_data_out,
  input  logic                        reg_ack_in,
  input  logic [AXI_DATA_WIDTH-1:0]   reg_rd_data_in
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("genevr_reg_master: TIMEOUT_CYCLES must be >= 2");
  end

  state_t state, state_n;

  logic                      aw_cap, aw_cap_n, w_cap, w_cap_n, ar_cap, ar_cap_n;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr, aw_addr_n, ar_addr, ar_addr_n;
  logic [AXI_DATA_WIDTH-1:0] w_data, w_data_n;
  logic                      w_full, w_full_n;
  logic                      prio_wr, prio_wr_n;

  logic                      awready_n, wready_n, arready_n;
  logic                      bvalid_n, rvalid_n, req_n, rd_wr_L_n;
  logic [1:0]                bresp_n, rresp_n;
  logic [AXI_DATA_WIDTH-1:0] rdata_n, wr_data_n;
  logic [AXI_ADDR_WIDTH-1:0] addr_n;

  logic aw_hs, w_hs, ar_hs;
  logic wr_pend, rd_pend, grant_wr;

`ifdef GENEVR_REG_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] bus_cnt, bus_cnt_n;
`endif

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid  && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // Next-state, capture and registered-output computation for the bridge FSM.
  always_comb begin
    state_n   = state;
    aw_cap_n  = aw_cap;
    w_cap_n   = w_cap;
    ar_cap_n  = ar_cap;
    aw_addr_n = aw_addr;
    ar_addr_n = ar_addr;
    w_data_n  = w_data;
    w_full_n  = w_full;
    prio_wr_n = prio_wr;
    bvalid_n  = s_axi_bvalid;
    bresp_n   = s_axi_bresp;
    rvalid_n  = s_axi_rvalid;
    rresp_n   = s_axi_rresp;
    rdata_n   = s_axi_rdata;
    req_n     = reg_req_out;
    rd_wr_L_n = reg_rd_wr_L_out;
    addr_n    = reg_addr_out;
    wr_data_n = reg_wr_data_out;
    wr_pend   = 1'b0;
    rd_pend   = 1'b0;
    grant_wr  = 1'b0;
`ifdef GENEVR_REG_TIMEOUT_EN
    bus_cnt_n = bus_cnt;
`endif

    case (state)
      ST_IDLE: begin
        if (aw_hs) begin
          aw_cap_n  = 1'b1;
          aw_addr_n = s_axi_awaddr;
        end
        if (w_hs) begin
          w_cap_n  = 1'b1;
          w_data_n = s_axi_wdata;
          w_full_n = &s_axi_wstrb;
        end
        if (ar_hs) begin
          ar_cap_n  = 1'b1;
          ar_addr_n = s_axi_araddr;
        end
        // Handshakes of this cycle count as captured so a launch can follow
        // the handshake edge directly.
        wr_pend  = aw_cap_n && w_cap_n;
        rd_pend  = ar_cap_n;
        grant_wr = wr_pend && (!rd_pend || prio_wr);
        // A still-high ack here is left over from the previous cycle.
        if (!reg_ack_in && (wr_pend || rd_pend)) begin
          prio_wr_n = !prio_wr;
`ifdef GENEVR_REG_TIMEOUT_EN
          bus_cnt_n = '0;
`endif
          if (grant_wr) begin
            aw_cap_n = 1'b0;
            w_cap_n  = 1'b0;
            if (!w_full_n) begin
              bvalid_n = 1'b1;
              bresp_n  = RESP_SLVERR;
              state_n  = ST_WR_RESP;
            end else begin
              req_n     = 1'b1;
              rd_wr_L_n = 1'b0;
              addr_n    = aw_addr_n;
              wr_data_n = w_data_n;
              state_n   = ST_BUS_WAIT;
            end
          end else begin
            ar_cap_n  = 1'b0;
            req_n     = 1'b1;
            rd_wr_L_n = 1'b1;
            addr_n    = ar_addr_n;
            state_n   = ST_BUS_WAIT;
          end
        end
      end

      ST_BUS_WAIT: begin
        if (reg_ack_in) begin
          req_n = 1'b0;
          if (reg_rd_wr_L_out) begin
            rdata_n  = reg_rd_data_in;
            rresp_n  = RESP_OKAY;
            rvalid_n = 1'b1;
            state_n  = ST_RD_RESP;
          end else begin
            bresp_n  = RESP_OKAY;
            bvalid_n = 1'b1;
            state_n  = ST_WR_RESP;
          end
        end
`ifdef GENEVR_REG_TIMEOUT_EN
        else if (bus_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          req_n = 1'b0;
          if (reg_rd_wr_L_out) begin
            rdata_n  = AXI_DATA_WIDTH'(DEAD_DATA);
            rresp_n  = RESP_SLVERR;
            rvalid_n = 1'b1;
            state_n  = ST_RD_RESP;
          end else begin
            bresp_n  = RESP_SLVERR;
            bvalid_n = 1'b1;
            state_n  = ST_WR_RESP;
          end
        end else begin
          bus_cnt_n = bus_cnt + CNT_W'(1);
        end
`endif
      end

      ST_WR_RESP: begin
        if (s_axi_bready) begin
          bvalid_n = 1'b0;
          state_n  = ST_IDLE;
        end
      end

      ST_RD_RESP: begin
        if (s_axi_rready) begin
          rvalid_n = 1'b0;
          state_n  = ST_IDLE;
        end
      end

      default: state_n = ST_IDLE;
    endcase

    // Readys are registered, so they are derived from the next-cycle state.
    awready_n = (state_n == ST_IDLE) && !aw_cap_n;
    wready_n  = (state_n == ST_IDLE) && !w_cap_n;
    arready_n = (state_n == ST_IDLE) && !ar_cap_n && !(aw_cap_n ^ w_cap_n);
  end

  // State, capture and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      aw_cap          <= 1'b0;
      w_cap           <= 1'b0;
      ar_cap          <= 1'b0;
      aw_addr         <= '0;
      ar_addr         <= '0;
      w_data          <= '0;
      w_full          <= 1'b0;
      prio_wr         <= 1'b1;
      s_axi_awready   <= 1'b0;
      s_axi_wready    <= 1'b0;
      s_axi_arready   <= 1'b0;
      s_axi_bvalid    <= 1'b0;
      s_axi_bresp     <= '0;
      s_axi_rvalid    <= 1'b0;
      s_axi_rresp     <= '0;
      s_axi_rdata     <= '0;
      reg_req_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out    <= '0;
      reg_wr_data_out <= '0;
`ifdef GENEVR_REG_TIMEOUT_EN
      bus_cnt         <= '0;
`endif
    end else begin
      state           <= state_n;
      aw_cap          <= aw_cap_n;
      w_cap           <= w_cap_n;
      ar_cap          <= ar_cap_n;
      aw_addr         <= aw_addr_n;
      ar_addr         <= ar_addr_n;
      w_data          <= w_data_n;
      w_full          <= w_full_n;
      prio_wr         <= prio_wr_n;
      s_axi_awready   <= awready_n;
      s_axi_wready    <= wready_n;
      s_axi_arready   <= arready_n;
      s_axi_bvalid    <= bvalid_n;
      s_axi_bresp     <= bresp_n;
      s_axi_rvalid    <= rvalid_n;
      s_axi_rresp     <= rresp_n;
      s_axi_rdata     <= rdata_n;
      reg_req_out     <= req_n;
      reg_rd_wr_L_out <= rd_wr_L_n;
      reg_addr_out    <= addr_n;
      reg_wr_data_out <= wr_data_n;
`ifdef GENEVR_REG_TIMEOUT_EN
      bus_cnt         <= bus_cnt_n;
`endif
    end
  end

endmodule

// File: doc/genevr_reg_master.md
Name: genevr_reg_master

Overview:
- AXI4-Lite slave to register-bus initiator bridge. Drives the req/ack register bus that the genevr pipeline register blocks respond on.
- Sits between the host AXI interconnect and the chain of register-file responders.
- Converts each single AXI read or write into exactly one register-bus transaction.
- Returns the responder's read data, or an error response on timeout or an unsupported strobe.

Parameters:
- AXI_DATA_WIDTH, 32, data width of AXI and register bus.
- AXI_ADDR_WIDTH, 26, address width, passed through unmodified.
- TIMEOUT_CYCLES, 256, maximum cycles to wait for reg_ack_in; used only with GENEVR_REG_TIMEOUT_EN; must be >= 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_axi_awaddr  in  AXI_ADDR_WIDTH  write address
- s_axi_awvalid / s_axi_awready  in/out  1  AW handshake
- s_axi_wdata  in  AXI_DATA_WIDTH  write data
- s_axi_wstrb  in  AXI_DATA_WIDTH/8  write strobes
- s_axi_wvalid / s_axi_wready  in/out  1  W handshake
- s_axi_bresp  out  2  write response
- s_axi_bvalid / s_axi_bready  out/in  1  B handshake
- s_axi_araddr  in  AXI_ADDR_WIDTH  read address
- s_axi_arvalid / s_axi_arready  in/out  1  AR handshake
- s_axi_rdata  out  AXI_DATA_WIDTH  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid / s_axi_rready  out/in  1  R handshake
- reg_req_out  out  1  bus request; held until ack or timeout
- reg_rd_wr_L_out  out  1  1 = read, 0 = write
- reg_addr_out  out  AXI_ADDR_WIDTH  bus address
- reg_wr_data_out  out  AXI_DATA_WIDTH  bus write data
- reg_ack_in  in  1  responder acknowledge
- reg_rd_data_in  in  AXI_DATA_WIDTH  responder read data, valid in the ack cycle

Behaviour:
- Reset: all outputs are registered and reset to 0.
  - This includes all readys, bvalid, rvalid, bresp, rresp, rdata, reg_req_out, reg_addr_out and reg_wr_data_out.
  - State resets to IDLE; captured-AW and captured-W flags clear; read/write priority resets to write.
- States: IDLE, BUS_WAIT, WR_RESP, RD_RESP.
- IDLE:
  - awready = !aw_captured; wready = !w_captured; arready = 1 unless a write is partially captured.
  - AW and W may arrive in either order or in the same cycle. Each is latched independently.
- Launch condition: a captured write (AW and W both held) or a captured read, AND reg_ack_in == 0 (ack-low guard).
  - Both a write and a read pending: use the priority bit, then toggle it after each grant.
- Write with wstrb != all-ones: no bus cycle; go to WR_RESP with bresp = 2'b10 (SLVERR).
- On launch:
  - reg_req_out <= 1; address, data and rd_wr_L are registered; enter BUS_WAIT.
  - All AXI readys are 0 outside IDLE.
- BUS_WAIT, reg_ack_in sampled 1:
  - reg_req_out <= 0.
  - Read: rdata <= reg_rd_data_in, rresp = 2'b00, go to RD_RESP.
  - Write: bresp = 2'b00, go to WR_RESP.
- WR_RESP / RD_RESP: bvalid / rvalid held high until the matching ready, then return to IDLE. rdata and resp stay stable while valid.
- Latency against a responder that acks one cycle after it samples the request:
  - Handshake at edge E; reg_req_out high after E; ack seen at E+2; rvalid/bvalid high after E+2.
- Ack persistence: the responder's ack may remain high for a cycle after reg_req_out drops. The ack-low guard prevents that stale ack from completing the next transaction.
- reg_ack_in outside BUS_WAIT is ignored.
- Reset mid-transaction: reg_req_out drops immediately; the pending AXI transaction is discarded with no response.

Optional Feature:
- GENEVR_REG_TIMEOUT_EN defined:
  - A cycle counter clears on launch and increments in BUS_WAIT while ack is low.
  - When it reaches TIMEOUT_CYCLES: reg_req_out <= 0; reads return rdata = 32'hdead_beef with rresp = 2'b10; writes return bresp = 2'b10.
  - A late ack is discarded by the ack-low guard.
  - Ack and timeout in the same cycle: ack wins, OKAY response.
- Undefined: no counter; BUS_WAIT waits for ack indefinitely.

Decomposition:
- Package genevr_reg_pkg:
  - AXI response codes (RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10).
  - DEAD_DATA = 32'hdead_beef.
  - FSM state encoding.
- Single module, no sub-module. The timeout counter is small and inline.

Test Plan:
- Write awaddr 26'h0400004, wdata 32'h12345678, full strobe -> one reg_req_out pulse with rd_wr_L = 0, addr 26'h0400004, data 32'h12345678; bresp OKAY.
- Read of the same address, responder returns 32'h12345678 -> rvalid two cycles after the AR handshake, rdata 32'h12345678, rresp OKAY.
- W presented 3 cycles before AW -> single bus write after AW arrives; no duplicate reg_req_out.
- Write and read asserted in the same cycle, twice -> first grant write, then read, then write, then read (alternating).
- wstrb = 4'b0011 -> no reg_req_out; bresp = 2'b10.
- GENEVR_REG_TIMEOUT_EN, TIMEOUT_CYCLES = 8, responder never acks on a read -> reg_req_out drops after 8 cycles; rdata 32'hdead_beef, rresp 2'b10. A stale ack held one extra cycle does not complete the next read.
